// File: rtl/mem_wait_arbiter.sv
// Arbitrates one RAM port between an instruction and a data requester (data wins ties).
// Latency: request seen in IDLE, completion LAT+1 cycles later (LAT+2 cycles incl. the IDLE cycle).
// Backpressure: the requester is stalled (iwait/dwait) until its completion cycle; a dropped request aborts.
module mem_wait_arbiter #(
  parameter int LAT      = 2,
  parameter int CNT_BITS = 4,
  parameter int ADDR_W   = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                iREN,
  input  logic [ADDR_W-1:0]   iaddr,
  input  logic                dREN,
  input  logic                dWEN,
  input  logic [ADDR_W-1:0]   daddr,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [ADDR_W-1:0]   ramaddr,
  output logic                iwait,
  output logic                dwait,
  output logic [CNT_BITS-1:0] wcount
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [CNT_BITS-1:0] LAT_C = CNT_BITS'(LAT);

  state_t              state_q;
  logic                gd_q;
  logic [CNT_BITS-1:0] cnt_q;

  logic d_req;
  logic g_req;
  logic in_access;
  logic at_lat;

  assign d_req     = dREN | dWEN;
  assign g_req     = gd_q ? d_req : iREN;
  assign in_access = (state_q == ACCESS);
  assign at_lat    = (cnt_q == LAT_C);

  // Arbitration, wait-state counting, completion and abort handling.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      gd_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
      if (d_req) begin
        state_q <= ACCESS;
        gd_q    <= 1'b1;
      end else if (iREN) begin
        state_q <= ACCESS;
        gd_q    <= 1'b0;
      end
    end else begin
      // Completion (count reached LAT) or abort (granted side withdrew): back to IDLE.
      if (!g_req || at_lat) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_BITS'(1);
      end
    end
  end

  // RAM strobes and address follow the granted side's live inputs during ACCESS.
  always_comb begin
    ramREN  = 1'b0;
    ramWEN  = 1'b0;
    ramaddr = '0;
    if (in_access) begin
      if (gd_q) begin
        ramWEN  = dWEN;
        ramREN  = dREN & ~dWEN;
        ramaddr = daddr;
      end else begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
    end
  end

  // Stall each side unless this is its completion cycle.
  always_comb begin
    iwait = iREN  & ~(in_access & ~gd_q & at_lat);
    dwait = d_req & ~(in_access &  gd_q & at_lat);
  end

  assign wcount = cnt_q;

endmodule

// File: tb/tb_mem_wait_arbiter.sv
// Self-checking bench for mem_wait_arbiter: LAT=2 instance plus a LAT=0 instance on shared inputs.
// Expected per-cycle outputs are queued as stimulus is driven and compared at the falling edge.
// Async reset is exercised mid-access and checked without waiting for a clock edge.
module tb_mem_wait_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;

  logic        a_ren, a_wen, a_iw, a_dw;
  logic [31:0] a_addr;
  logic [3:0]  a_cnt;
  logic        b_ren, b_wen, b_iw, b_dw;
  logic [31:0] b_addr;
  logic [3:0]  b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        sel;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic        iw;
    logic        dw;
    logic [3:0]  cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  mem_wait_arbiter #(.LAT(2), .CNT_BITS(4), .ADDR_W(32)) dut_a (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .ramREN(a_ren), .ramWEN(a_wen), .ramaddr(a_addr),
    .iwait(a_iw), .dwait(a_dw), .wcount(a_cnt)
  );

  mem_wait_arbiter #(.LAT(0), .CNT_BITS(4), .ADDR_W(32)) dut_b (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .ramREN(b_ren), .ramWEN(b_wen), .ramaddr(b_addr),
    .iwait(b_iw), .dwait(b_dw), .wcount(b_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_front();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    if (e.sel) begin
      check_val({t, ".ren"},  {31'd0, b_ren}, {31'd0, e.ren});
      check_val({t, ".wen"},  {31'd0, b_wen}, {31'd0, e.wen});
      check_val({t, ".addr"}, b_addr,         e.addr);
      check_val({t, ".iw"},   {31'd0, b_iw},  {31'd0, e.iw});
      check_val({t, ".dw"},   {31'd0, b_dw},  {31'd0, e.dw});
      check_val({t, ".cnt"},  {28'd0, b_cnt}, {28'd0, e.cnt});
    end else begin
      check_val({t, ".ren"},  {31'd0, a_ren}, {31'd0, e.ren});
      check_val({t, ".wen"},  {31'd0, a_wen}, {31'd0, e.wen});
      check_val({t, ".addr"}, a_addr,         e.addr);
      check_val({t, ".iw"},   {31'd0, a_iw},  {31'd0, e.iw});
      check_val({t, ".dw"},   {31'd0, a_dw},  {31'd0, e.dw});
      check_val({t, ".cnt"},  {28'd0, a_cnt}, {28'd0, e.cnt});
    end
  endtask

  // Called at posedge+1: drive inputs, queue the expected outputs, compare at negedge.
  task automatic step(input string tag,
                      input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dwr, input logic [31:0] da,
                      input logic sel,
                      input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
                      input logic e_iw, input logic e_dw, input logic [3:0] e_cnt);
    exp_t e;
    iREN  = ir;
    iaddr = ia;
    dREN  = dr;
    dWEN  = dwr;
    daddr = da;
    e.sel  = sel;
    e.ren  = e_ren;
    e.wen  = e_wen;
    e.addr = e_addr;
    e.iw   = e_iw;
    e.dw   = e_dw;
    e.cnt  = e_cnt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge CLK);
    compare_front();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST  = 1'b0;
    iREN  = 1'b1;
    iaddr = 32'h100;
    dREN  = 1'b0;
    dWEN  = 1'b0;
    daddr = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    // Reset: strobes/address/count zero, waits equal to the requests.
    check_val("rst.ren",  {31'd0, a_ren}, 32'd0);
    check_val("rst.wen",  {31'd0, a_wen}, 32'd0);
    check_val("rst.addr", a_addr,         32'd0);
    check_val("rst.cnt",  {28'd0, a_cnt}, 32'd0);
    check_val("rst.iw",   {31'd0, a_iw},  32'd1);
    check_val("rst.dw",   {31'd0, a_dw},  32'd0);
    iREN = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Single instruction read (LAT=2).
    step("ird0", 1, 32'h100, 0, 0, 0, 0,  0, 0, 32'h000, 1, 0, 0);
    step("ird1", 1, 32'h100, 0, 0, 0, 0,  1, 0, 32'h100, 1, 0, 0);
    step("ird2", 1, 32'h100, 0, 0, 0, 0,  1, 0, 32'h100, 1, 0, 1);
    step("ird3", 1, 32'h100, 0, 0, 0, 0,  1, 0, 32'h100, 0, 0, 2);
    step("ird4", 0, 32'h100, 0, 0, 0, 0,  0, 0, 32'h000, 0, 0, 0);

    // Simultaneous requests: data first, instruction afterwards.
    step("sim0", 1, 32'h100, 1, 0, 32'h300, 0,  0, 0, 32'h000, 1, 1, 0);
    step("sim1", 1, 32'h100, 1, 0, 32'h300, 0,  1, 0, 32'h300, 1, 1, 0);
    step("sim2", 1, 32'h100, 1, 0, 32'h300, 0,  1, 0, 32'h300, 1, 1, 1);
    step("sim3", 1, 32'h100, 1, 0, 32'h300, 0,  1, 0, 32'h300, 1, 0, 2);
    step("sim4", 1, 32'h100, 0, 0, 32'h300, 0,  0, 0, 32'h000, 1, 0, 0);
    step("sim5", 1, 32'h100, 0, 0, 32'h300, 0,  1, 0, 32'h100, 1, 0, 0);
    step("sim6", 1, 32'h100, 0, 0, 32'h300, 0,  1, 0, 32'h100, 1, 0, 1);
    step("sim7", 1, 32'h100, 0, 0, 32'h300, 0,  1, 0, 32'h100, 0, 0, 2);
    step("sim8", 0, 32'h100, 0, 0, 32'h300, 0,  0, 0, 32'h000, 0, 0, 0);

    // Write wins over read; held request re-arbitrates after one IDLE; then data abort.
    step("wr0", 0, 0, 1, 1, 32'h2000, 0,  0, 0, 32'h0000, 0, 1, 0);
    step("wr1", 0, 0, 1, 1, 32'h2000, 0,  0, 1, 32'h2000, 0, 1, 0);
    step("wr2", 0, 0, 1, 1, 32'h2000, 0,  0, 1, 32'h2000, 0, 1, 1);
    step("wr3", 0, 0, 1, 1, 32'h2000, 0,  0, 1, 32'h2000, 0, 0, 2);
    step("wr4", 0, 0, 1, 1, 32'h2000, 0,  0, 0, 32'h0000, 0, 1, 0);
    step("wr5", 0, 0, 1, 1, 32'h2000, 0,  0, 1, 32'h2000, 0, 1, 0);
    step("wr6", 0, 0, 0, 0, 32'h2000, 0,  0, 0, 32'h2000, 0, 0, 1);
    step("wr7", 0, 0, 0, 0, 32'h2000, 0,  0, 0, 32'h0000, 0, 0, 0);

    // Instruction abort at wcount=1: no iwait low pulse, back to IDLE.
    step("ab0", 1, 32'h40, 0, 0, 0, 0,  0, 0, 32'h00, 1, 0, 0);
    step("ab1", 1, 32'h40, 0, 0, 0, 0,  1, 0, 32'h40, 1, 0, 0);
    step("ab2", 0, 32'h40, 0, 0, 0, 0,  0, 0, 32'h40, 0, 0, 1);
    step("ab3", 0, 32'h40, 0, 0, 0, 0,  0, 0, 32'h00, 0, 0, 0);

    // Instruction request arriving during a data access waits, then runs.
    step("nw0", 0, 32'h600, 1, 0, 32'h500, 0,  0, 0, 32'h000, 0, 1, 0);
    step("nw1", 0, 32'h600, 1, 0, 32'h500, 0,  1, 0, 32'h500, 0, 1, 0);
    step("nw2", 1, 32'h600, 1, 0, 32'h500, 0,  1, 0, 32'h500, 1, 1, 1);
    step("nw3", 1, 32'h600, 1, 0, 32'h500, 0,  1, 0, 32'h500, 1, 0, 2);
    step("nw4", 1, 32'h600, 0, 0, 32'h500, 0,  0, 0, 32'h000, 1, 0, 0);
    step("nw5", 1, 32'h600, 0, 0, 32'h500, 0,  1, 0, 32'h600, 1, 0, 0);
    step("nw6", 1, 32'h600, 0, 0, 32'h500, 0,  1, 0, 32'h600, 1, 0, 1);
    step("nw7", 1, 32'h600, 0, 0, 32'h500, 0,  1, 0, 32'h600, 0, 0, 2);
    step("nw8", 0, 32'h600, 0, 0, 32'h500, 0,  0, 0, 32'h000, 0, 0, 0);

    // Async reset mid-access with wcount=1.
    step("ar0", 1, 32'h80, 0, 0, 0, 0,  0, 0, 32'h00, 1, 0, 0);
    step("ar1", 1, 32'h80, 0, 0, 0, 0,  1, 0, 32'h80, 1, 0, 0);
    iREN  = 1'b1;
    iaddr = 32'h80;
    @(negedge CLK);
    check_val("ar2.cnt", {28'd0, a_cnt}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check_val("arst.ren",  {31'd0, a_ren}, 32'd0);
    check_val("arst.cnt",  {28'd0, a_cnt}, 32'd0);
    check_val("arst.addr", a_addr,         32'd0);
    check_val("arst.iw",   {31'd0, a_iw},  32'd1);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    step("ar3", 1, 32'h80, 0, 0, 0, 0,  0, 0, 32'h00, 1, 0, 0);
    step("ar4", 1, 32'h80, 0, 0, 0, 0,  1, 0, 32'h80, 1, 0, 0);
    step("ar5", 1, 32'h80, 0, 0, 0, 0,  1, 0, 32'h80, 1, 0, 1);
    step("ar6", 1, 32'h80, 0, 0, 0, 0,  1, 0, 32'h80, 0, 0, 2);
    step("ar7", 0, 32'h80, 0, 0, 0, 0,  0, 0, 32'h00, 0, 0, 0);

    // LAT=0 instance: write completes in the first ACCESS cycle.
    step("z0", 0, 0, 0, 1, 32'h700, 1,  0, 0, 32'h000, 0, 1, 0);
    step("z1", 0, 0, 0, 1, 32'h700, 1,  0, 1, 32'h700, 0, 0, 0);
    step("z2", 0, 0, 0, 1, 32'h700, 1,  0, 0, 32'h000, 0, 1, 0);
    step("z3", 0, 0, 0, 0, 32'h700, 1,  0, 0, 32'h700, 0, 0, 0);
    step("z4", 0, 0, 0, 0, 32'h700, 1,  0, 0, 32'h000, 0, 0, 0);

    check_val("sb.empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_wait_arbiter.md
MEM_WAIT_ARBITER -- requirements
Module: mem_wait_arbiter

Interface
REQ-001 Parameter LAT, default 2, meaning RAM wait states per access (legal range 0 to 2^CNT_BITS-1).
REQ-002 Parameter CNT_BITS, default 4, meaning wait-state counter width.
REQ-003 Parameter ADDR_W, default 32, meaning address width.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 nRST  in  1  asynchronous reset, active low.
REQ-006 iREN  in  1  instruction-side read request.
REQ-007 iaddr  in  ADDR_W  instruction-side address.
REQ-008 dREN  in  1  data-side read request.
REQ-009 dWEN  in  1  data-side write request.
REQ-010 daddr  in  ADDR_W  data-side address.
REQ-011 ramREN  out  1  RAM read strobe.
REQ-012 ramWEN  out  1  RAM write strobe.
REQ-013 ramaddr  out  ADDR_W  RAM address.
REQ-014 iwait  out  1  instruction side stalled.
REQ-015 dwait  out  1  data side stalled.
REQ-016 wcount  out  CNT_BITS  current wait-state count.

Function
REQ-017 FSM states SHALL be IDLE and ACCESS; registered grant flag gD (1 = data side, 0 = instruction side).
REQ-018 IDLE: if dREN|dWEN, go ACCESS with gD=1; else if iREN, go ACCESS with gD=0; else stay IDLE; counter loads 0 on every IDLE->ACCESS transition.
REQ-019 Data side SHALL have fixed priority over instruction side on simultaneous requests.
REQ-020 ACCESS: counter SHALL increment by 1 per cycle while count != LAT; it never wraps, because completion is taken at count == LAT.
REQ-021 Completion cycle = ACCESS with count == LAT and granted request still asserted; next state IDLE, counter cleared to 0.
REQ-022 Abort: in ACCESS, if the granted side deasserts all its request lines, next state IDLE, counter cleared, and no completion is signalled.
REQ-023 Outputs are combinational from state and inputs: in IDLE, ramREN=ramWEN=0 and ramaddr=0; in ACCESS, ramaddr = granted side address (live input).
REQ-024 ACCESS with gD=1: ramWEN=dWEN and ramREN=dREN&~dWEN (write wins when dREN and dWEN are both high); with gD=0: ramREN=iREN and ramWEN=0.
REQ-025 iwait = iREN & ~(ACCESS & ~gD & count==LAT); dwait = (dREN|dWEN) & ~(ACCESS & gD & count==LAT).
REQ-026 LAT=0: completion SHALL occur in the first ACCESS cycle (access latency 2 cycles from request in IDLE).
REQ-027 A request held high after completion SHALL be treated as a new request: IDLE for one cycle, then re-arbitrated.
REQ-028 A non-granted request arriving during ACCESS SHALL wait (wait=1) and is arbitrated in the next IDLE cycle.
REQ-029 wcount SHALL equal the internal counter value at all times.

Reset
REQ-030 When nRST=0, state SHALL be IDLE, gD=0, and counter=0 immediately, independent of CLK.
REQ-031 During reset: ramREN=ramWEN=0, ramaddr=0, wcount=0; iwait and dwait follow the REQ-025 formulas (equal to the requests).
REQ-032 Reset asserted mid-ACCESS SHALL abandon the access with no completion; after release, operation resumes from IDLE.

Verification (LAT=2)
REQ-033 Single instruction read: iREN=1, iaddr=0x100 from IDLE.
  - Cycles 1-3: ramREN=1, ramaddr=0x100, wcount 0,1,2.
  - iwait=1 through cycle 2, iwait=0 in cycle 3.
  - Cycle 4: IDLE.
REQ-034 Simultaneous requests: iREN=dREN=1 in IDLE.
  - Data access runs first (cycles 1-3, dwait=0 in cycle 3), with iwait=1 throughout.
  - Cycle 4: IDLE.
  - Instruction access then runs in cycles 5-7.
REQ-035 Write precedence: dREN=dWEN=1, daddr=0x2000.
  - ACCESS cycles: ramWEN=1, ramREN=0, ramaddr=0x2000.
REQ-036 Abort: drop iREN in cycle 2 of ACCESS (wcount=1).
  - Next cycle: IDLE, wcount=0, ramREN=0, no iwait low pulse.
REQ-037 Async reset: assert nRST=0 mid-cycle with wcount=1.
  - Outputs immediately ramREN=0, wcount=0.
  - After release with iREN=1: fresh access completing in cycle 3.
REQ-038 LAT=0 build: dWEN=1.
  - Cycle 1: ramWEN=1, dwait=0.
  - Cycle 2: IDLE.
